// File: rtl/seq_mon_pkg.sv
// Shared types and constants for the sequence cover monitor.
package seq_mon_pkg;

    localparam int unsigned DELAY_MAX   = 16;
    localparam int unsigned COUNT_W_MAX = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [COUNT_W_MAX-1:0] count;
        logic                   ovf;
    } rpt_t;

endpackage

// File: rtl/seq_mon_report_reg.sv
// Single-entry valid/ready report holding register with sticky overflow.
module seq_mon_report_reg
    import seq_mon_pkg::*;
#(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_count,
    input  logic               ready,
    output logic               valid,
    output rpt_t               rpt
);

    logic [COUNT_W-1:0] count_q;
    logic               valid_q;
    logic               ovf_q;

    // A new report may replace the held one only when the slot is empty or being accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (load) begin
            if (!valid_q || ready) begin
                count_q <= load_count;
                valid_q <= 1'b1;
            end else begin
                ovf_q <= 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign rpt   = '{count: COUNT_W_MAX'(count_q), ovf: ovf_q};

endmodule

// File: rtl/seq_cover_monitor.sv
// Synthesizable monitor for "x ##DELAY y": per-match pulse, lifetime count,
// and per-window match reports over a valid/ready handshake.
module seq_cover_monitor
    import seq_mon_pkg::*;
#(
    parameter int unsigned DELAY   = 1,
    parameter int unsigned COUNT_W = 16,
    parameter int unsigned WIN_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [WIN_W-1:0]   win_len,
    input  logic               x,
    input  logic               y,
    output logic               hit,
    output logic [COUNT_W-1:0] total,
    output logic               rpt_valid,
    output logic [COUNT_W-1:0] rpt_count,
    input  logic               rpt_ready,
    output logic               rpt_ovf
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    generate
        if (DELAY < 1 || DELAY > DELAY_MAX) begin : g_bad_delay
            $error("seq_cover_monitor: DELAY out of range");
        end
        if (COUNT_W > COUNT_W_MAX) begin : g_bad_count_w
            $error("seq_cover_monitor: COUNT_W too wide");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [DELAY-1:0]   x_hist_q;
    logic [WIN_W-1:0]   win_last_q;
    logic [WIN_W-1:0]   win_cnt_q;
    logic [COUNT_W-1:0] run_cnt_q;
    logic [COUNT_W-1:0] total_q;
    logic               hit_q;

    logic               match_c;
    logic               win_end_c;
    logic [COUNT_W-1:0] run_cnt_next_c;

    rpt_t                   rpt;
    logic [COUNT_W_MAX-1:0] rpt_count_unused;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state plus per-cycle match and window-end decode
    always_comb begin
        state_d        = state_q;
        match_c        = 1'b0;
        win_end_c      = 1'b0;
        run_cnt_next_c = run_cnt_q;
        case (state_q)
            IDLE: begin
                if (en) state_d = RUN;
            end
            RUN: begin
                match_c   = x_hist_q[DELAY-1] && y;
                win_end_c = en && (win_cnt_q == win_last_q);
                if (match_c && run_cnt_q != CNT_MAX) run_cnt_next_c = run_cnt_q + COUNT_W'(1);
                if (!en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // History, window counters and lifetime total
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_hist_q   <= '0;
            win_last_q <= '0;
            win_cnt_q  <= '0;
            run_cnt_q  <= '0;
            total_q    <= '0;
            hit_q      <= 1'b0;
        end else begin
            hit_q <= match_c;
            if (match_c && total_q != CNT_MAX) total_q <= total_q + COUNT_W'(1);
            if (state_q == IDLE) begin
                x_hist_q  <= '0;
                win_cnt_q <= '0;
                run_cnt_q <= '0;
                // Store length-1 so a zero length behaves as a one-cycle window
                if (en) win_last_q <= (win_len == '0) ? '0 : win_len - WIN_W'(1);
            end else begin
                x_hist_q <= (x_hist_q << 1) | DELAY'(x);
                if (win_end_c || !en) begin
                    win_cnt_q <= '0;
                    run_cnt_q <= '0;
                end else begin
                    win_cnt_q <= win_cnt_q + WIN_W'(1);
                    run_cnt_q <= run_cnt_next_c;
                end
            end
        end
    end

    seq_mon_report_reg #(
        .COUNT_W (COUNT_W)
    ) u_report (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (win_end_c),
        .load_count (run_cnt_next_c),
        .ready      (rpt_ready),
        .valid      (rpt_valid),
        .rpt        (rpt)
    );

    // Bits above COUNT_W in the shared report width are always zero
    assign rpt_count_unused = rpt.count;
    assign rpt_count        = rpt.count[COUNT_W-1:0];
    assign rpt_ovf          = rpt.ovf;
    assign hit              = hit_q;
    assign total            = total_q;

endmodule
